alu_mc: RTL and testbench

- Parametrised multi-cycle ALU for the next CPU generation, replacing the purely combinational ALU used in the single-cycle datapath.
- Single-cycle ops return a registered result one cycle after acceptance.
- MUL and DIVU run iteratively, one bit per cycle.
- A start/ready/done handshake lets the control unit stall the pipeline while the block is busy.

---
 rtl/alu_mc.sv | 197 +++++++++++++++++++
 tb/tb_alu_mc.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with start/ready/done handshake.
// Single-cycle ops finish in one cycle; MUL/DIVU iterate one bit per cycle.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SRA  = 4'd3;
  localparam logic [3:0] OP_SEQ  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SNE  = 4'd10;
  localparam logic [3:0] OP_SLL  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_LUI  = 4'd14;
  localparam logic [3:0] OP_NOR  = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;

  logic [WIDTH:0]   div_r;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;

  logic             last;

  assign ready_o = (state == IDLE) || (state == DONE);
  assign last    = (cnt == CW'(1));

  assign sum   = src1_i + src2_i;
  assign diff  = src1_i - src2_i;
  assign shamt = src2_i[SHW-1:0];

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    unique case (ctrl_i)
      OP_AND:  sc_res = src1_i & src2_i;
      OP_OR:   sc_res = src1_i | src2_i;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                 (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SRA:  sc_res = WIDTH'($signed(src1_i) >>> shamt);
      OP_SEQ:  sc_res = WIDTH'(src1_i == src2_i);
      OP_SLTU: sc_res = WIDTH'(src1_i < src2_i);
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                 (diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SLT:  sc_res = WIDTH'($signed(src1_i) < $signed(src2_i));
      OP_XOR:  sc_res = src1_i ^ src2_i;
      OP_SRL:  sc_res = src1_i >> shamt;
      OP_SNE:  sc_res = WIDTH'(src1_i != src2_i);
      OP_SLL:  sc_res = src1_i << shamt;
      OP_LUI:  sc_res = src2_i << (WIDTH / 2);
      OP_NOR:  sc_res = ~(src1_i | src2_i);
      default: sc_res = '0;
    endcase
  end

  // Shift-add: hi_q accumulates, lo_q holds the unconsumed multiplier bits.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  // Restoring divide: hi_q is the partial remainder, lo_q shifts
  // dividend bits out and quotient bits in. A zero divisor naturally
  // yields all-ones quotient and remainder equal to the dividend.
  always_comb begin
    div_r    = {hi_q, lo_q[WIDTH-1]};
    div_sub  = div_r - {1'b0, b_q};
    div_ge   = (div_r >= {1'b0, b_q});
    div_hi_n = div_ge ? div_sub[WIDTH-1:0] : div_r[WIDTH-1:0];
    div_lo_n = {lo_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_o      <= 1'b0;
      result_o    <= '0;
      result_hi_o <= '0;
      zero_o      <= 1'b1;
      ovf_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start_i) begin
            b_q <= src2_i;
            if (ctrl_i == OP_MUL) begin
              state <= MUL;
              hi_q  <= '0;
              lo_q  <= src1_i;
              cnt   <= CW'(WIDTH);
            end else if (ctrl_i == OP_DIVU) begin
              state <= DIV;
              hi_q  <= '0;
              lo_q  <= src1_i;
              cnt   <= CW'(WIDTH);
            end else begin
              state       <= DONE;
              done_o      <= 1'b1;
              result_o    <= sc_res;
              result_hi_o <= '0;
              zero_o      <= (sc_res == '0);
              ovf_o       <= sc_ovf;
            end
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          hi_q <= mul_hi_n;
          lo_q <= mul_lo_n;
          cnt  <= cnt - CW'(1);
          if (last) begin
            state       <= DONE;
            done_o      <= 1'b1;
            result_o    <= mul_lo_n;
            result_hi_o <= mul_hi_n;
            zero_o      <= (mul_lo_n == '0);
            ovf_o       <= 1'b0;
          end
        end
        DIV: begin
          hi_q <= div_hi_n;
          lo_q <= div_lo_n;
          cnt  <= cnt - CW'(1);
          if (last) begin
            state       <= DONE;
            done_o      <= 1'b1;
            result_o    <= div_lo_n;
            result_hi_o <= div_hi_n;
            zero_o      <= (div_lo_n == '0);
            ovf_o       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed self-checking bench for alu_mc.
// Expected values come from a plain-arithmetic model of each opcode.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        ovf;

  int n_chk = 0;
  int n_fail = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .ctrl_i(ctrl),
    .src1_i(src1),
    .src2_i(src2),
    .ready_o(ready),
    .done_o(done),
    .result_o(result),
    .result_hi_o(result_hi),
    .zero_o(zero),
    .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Returns {ovf, hi, lo}.
  function automatic logic [64:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] lo;
    logic [31:0] hi;
    logic        v;
    logic [63:0] p;
    longint      s;
    logic [4:0]  sh;
    lo = '0;
    hi = '0;
    v  = 1'b0;
    sh = b[4:0];
    case (op)
      4'd0:  lo = a & b;
      4'd1:  lo = a | b;
      4'd2: begin
        lo = a + b;
        s  = longint'($signed(a)) + longint'($signed(b));
        v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3:  lo = $signed(a) >>> sh;
      4'd4:  lo = (a == b) ? 32'd1 : 32'd0;
      4'd5:  lo = (a < b) ? 32'd1 : 32'd0;
      4'd6: begin
        lo = a - b;
        s  = longint'($signed(a)) - longint'($signed(b));
        v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7:  lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  lo = a ^ b;
      4'd9:  lo = a >> sh;
      4'd10: lo = (a != b) ? 32'd1 : 32'd0;
      4'd11: lo = a << sh;
      4'd12: begin
        p  = {32'd0, a} * {32'd0, b};
        lo = p[31:0];
        hi = p[63:32];
      end
      4'd13: begin
        if (b == 0) begin
          lo = 32'hFFFFFFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      4'd14: lo = b << 16;
      default: lo = ~(a | b);
    endcase
    return {v, hi, lo};
  endfunction

  // Drives one request and waits (bounded) for done; lat counts cycles
  // after the accepting edge, busy counts cycles seen with ready low.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output int busy);
    @(negedge clk);
    start = 1'b1;
    ctrl  = op;
    src1  = a;
    src2  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    src1  = $urandom;
    src2  = $urandom;
    lat   = 1;
    busy  = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (ready === 1'b0) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk += 6;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", ready); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
    if (result !== 32'd0) begin n_fail++; $display("FAIL rst_result got %h exp 0", result); end
    if (result_hi !== 32'd0) begin n_fail++; $display("FAIL rst_hi got %h exp 0", result_hi); end
    if (zero !== 1'b1) begin n_fail++; $display("FAIL rst_zero got %b exp 1", zero); end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_ovf;
    int lat, busy;
    run_op(4'd2, 32'h7FFFFFFF, 32'd1, lat, busy);
    n_chk += 5;
    if (lat != 1) begin n_fail++; $display("FAIL add_lat got %0d exp 1", lat); end
    if (result !== 32'h80000000) begin n_fail++; $display("FAIL add_res got %h exp 80000000", result); end
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL add_ovf got %b exp 1", ovf); end
    if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero got %b exp 0", zero); end
    if (ready !== 1'b1 || busy != 0) begin n_fail++; $display("FAIL add_ready got %b/%0d exp 1/0", ready, busy); end
  endtask

  task automatic test_directed;
    logic [3:0]  ops [8] = '{4'd3, 4'd9, 4'd7, 4'd5, 4'd11, 4'd6, 4'd4, 4'd14};
    logic [31:0] as  [8] = '{32'hF0000000, 32'hF0000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h12345678, 32'h80000000, 32'd9, 32'd0};
    logic [31:0] bs  [8] = '{32'd4, 32'd4, 32'd1, 32'd1, 32'hFFFFFFE0, 32'd1, 32'd10, 32'h0000ABCD};
    logic [31:0] exp [8] = '{32'hFF000000, 32'h0F000000, 32'd1, 32'd0,
                             32'h12345678, 32'h7FFFFFFF, 32'd0, 32'hABCD0000};
    logic        eov [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat, busy;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], lat, busy);
      n_chk += 3;
      if (result !== exp[i]) begin n_fail++; $display("FAIL dir%0d_res got %h exp %h", i, result, exp[i]); end
      if (ovf !== eov[i]) begin n_fail++; $display("FAIL dir%0d_ovf got %b exp %b", i, ovf, eov[i]); end
      if (zero !== (exp[i] == 0)) begin n_fail++; $display("FAIL dir%0d_zero got %b exp %b", i, zero, exp[i] == 0); end
    end
  endtask

  task automatic test_mul;
    int lat, busy;
    run_op(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy);
    n_chk += 4;
    if (lat != 33) begin n_fail++; $display("FAIL mul_lat got %0d exp 33", lat); end
    if (busy != 32) begin n_fail++; $display("FAIL mul_busy got %0d exp 32", busy); end
    if (result !== 32'd1) begin n_fail++; $display("FAIL mul_lo got %h exp 1", result); end
    if (result_hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mul_hi got %h exp fffffffe", result_hi); end
  endtask

  task automatic test_divu;
    logic [31:0] as [3] = '{32'd100, 32'd5, 32'd3};
    logic [31:0] bs [3] = '{32'd7, 32'd0, 32'd10};
    logic [31:0] eq [3] = '{32'd14, 32'hFFFFFFFF, 32'd0};
    logic [31:0] er [3] = '{32'd2, 32'd5, 32'd3};
    int lat, busy;
    for (int i = 0; i < 3; i++) begin
      run_op(4'd13, as[i], bs[i], lat, busy);
      n_chk += 4;
      if (lat != 33) begin n_fail++; $display("FAIL div%0d_lat got %0d exp 33", i, lat); end
      if (result !== eq[i]) begin n_fail++; $display("FAIL div%0d_q got %h exp %h", i, result, eq[i]); end
      if (result_hi !== er[i]) begin n_fail++; $display("FAIL div%0d_r got %h exp %h", i, result_hi, er[i]); end
      if (zero !== (eq[i] == 0)) begin n_fail++; $display("FAIL div%0d_zero got %b", i, zero); end
    end
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [64:0] m;
    int lat, busy, elat;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 5) == 0) ? 32'h7FFFFFFF : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (op == 4'd13 && $urandom_range(0, 1) == 0) b = b >> $urandom_range(8, 31);
      m    = model(op, a, b);
      elat = (op == 4'd12 || op == 4'd13) ? 33 : 1;
      run_op(op, a, b, lat, busy);
      n_chk += 5;
      if (lat != elat) begin n_fail++; $display("FAIL rnd%0d_lat op %0d got %0d exp %0d", i, op, lat, elat); end
      if (result !== m[31:0]) begin n_fail++; $display("FAIL rnd%0d_lo op %0d a %h b %h got %h exp %h", i, op, a, b, result, m[31:0]); end
      if (result_hi !== m[63:32]) begin n_fail++; $display("FAIL rnd%0d_hi op %0d got %h exp %h", i, op, result_hi, m[63:32]); end
      if (ovf !== m[64]) begin n_fail++; $display("FAIL rnd%0d_ovf op %0d got %b exp %b", i, op, ovf, m[64]); end
      if (zero !== (m[31:0] == 0)) begin n_fail++; $display("FAIL rnd%0d_zero op %0d got %b", i, op, zero); end
    end
  endtask

  task automatic test_ignore_busy;
    logic [31:0] held, lo, hi;
    int ndone, at;
    @(negedge clk);
    start = 1'b1;
    ctrl  = 4'd12;
    src1  = 32'hFFFFFFFF;
    src2  = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    held  = result;
    ndone = 0;
    at    = 0;
    lo    = '0;
    hi    = '0;
    for (int c = 1; c <= 45; c++) begin
      if (done === 1'b1) begin
        ndone++;
        at = c;
        lo = result;
        hi = result_hi;
      end
      if (c == 20) begin
        n_chk++;
        if (result !== held) begin n_fail++; $display("FAIL busy_hold got %h exp %h", result, held); end
      end
      @(negedge clk);
      start = (c == 5);
      ctrl  = (c == 5) ? 4'd2 : 4'd12;
      src1  = (c == 5) ? 32'd123 : 32'hFFFFFFFF;
      @(posedge clk);
      #1;
    end
    n_chk += 4;
    if (ndone != 1) begin n_fail++; $display("FAIL busy_ndone got %0d exp 1", ndone); end
    if (at != 33) begin n_fail++; $display("FAIL busy_lat got %0d exp 33", at); end
    if (lo !== 32'd1) begin n_fail++; $display("FAIL busy_lo got %h exp 1", lo); end
    if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL busy_hi got %h exp fffffffe", hi); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1;
    ctrl  = 4'd2;
    src1  = 32'd10;
    src2  = 32'd20;
    @(posedge clk);
    #1;
    n_chk += 2;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done0 got %b exp 1", done); end
    if (result !== 32'd30) begin n_fail++; $display("FAIL b2b_res0 got %h exp 1e", result); end
    @(negedge clk);
    ctrl = 4'd8;
    src1 = 32'hFF00FF00;
    src2 = 32'h0F0F0F0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_chk += 2;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 got %b exp 1", done); end
    if (result !== 32'hF00FF00F) begin n_fail++; $display("FAIL b2b_res1 got %h exp f00ff00f", result); end
    @(posedge clk);
    #1;
    n_chk += 3;
    if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done2 got %b exp 0", done); end
    if (result !== 32'hF00FF00F) begin n_fail++; $display("FAIL b2b_hold got %h exp f00ff00f", result); end
    if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", ready); end
  endtask

  task automatic test_reset_mid;
    int lat, busy, ndone;
    run_op(4'd2, 32'd5, 32'd5, lat, busy);
    @(negedge clk);
    start = 1'b1;
    ctrl  = 4'd13;
    src1  = 32'd100;
    src2  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk += 4;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b exp 1", ready); end
    if (result !== 32'd0) begin n_fail++; $display("FAIL mid_result got %h exp 0", result); end
    if (zero !== 1'b1) begin n_fail++; $display("FAIL mid_zero got %b exp 1", zero); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b exp 0", done); end
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    n_chk++;
    if (ndone != 0) begin n_fail++; $display("FAIL mid_nodone got %0d exp 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_directed();
    test_mul();
    test_divu();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
